// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates per-column partial-sum rows from the systolic array across
// K-tile passes into a DEPTH-row buffer and drains finished rows in order.
// Optional build macro: PSUM_ACC_SAT_EN (saturating per-lane adds on non-first passes).
module psum_accumulator #(
  parameter int ARRWIDTH  = 8,
  parameter int WORDWIDTH = 8,
  parameter int DEPTH     = 16,
  localparam int ACCW     = WORDWIDTH * 4,
  localparam int ADDRW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     ps_valid,
  output logic                     ps_ready,
  input  logic                     ps_first,
  input  logic                     ps_last,
  input  logic [ACCW*ARRWIDTH-1:0] ps_in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACCW*ARRWIDTH-1:0] out_vec,
  output logic [ADDRW-1:0]         out_row
);

  // Handshake (both ports): a transfer happens on the clock edge where valid && ready are
  // both high; ready never depends on valid, and a producer holds its payload until taken.

  logic [ACCW-1:0]  row_buf [DEPTH][ARRWIDTH];
  logic [DEPTH-1:0] done;
  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic             accept;
  logic             drain;
  logic [ACCW-1:0]  new_row [ARRWIDTH];

  function automatic logic [ADDRW-1:0] next_ptr(input logic [ADDRW-1:0] p);
    return (p == ADDRW'(DEPTH - 1)) ? '0 : p + ADDRW'(1);
  endfunction

  function automatic logic [ACCW-1:0] lane_add(input logic [ACCW-1:0] a,
                                                input logic [ACCW-1:0] b);
    logic [ACCW-1:0] s;
    s = a + b;
`ifdef PSUM_ACC_SAT_EN
    // Signed overflow only when both operands share a sign the result does not.
    if ((a[ACCW-1] == b[ACCW-1]) && (s[ACCW-1] != a[ACCW-1])) begin
      s = a[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  assign ps_ready  = !done[wr_ptr];
  assign out_valid = done[rd_ptr];
  assign out_row   = rd_ptr;
  assign accept    = ps_valid && ps_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    out_vec = '0;
    for (int l = 0; l < ARRWIDTH; l++) begin
      out_vec[l*ACCW +: ACCW] = row_buf[rd_ptr][l];
    end
  end

  always_comb begin
    for (int l = 0; l < ARRWIDTH; l++) begin
      new_row[l] = '0;
      if (ps_first) begin
        new_row[l] = ps_in_vec[l*ACCW +: ACCW];
      end else begin
        new_row[l] = lane_add(row_buf[wr_ptr][l], ps_in_vec[l*ACCW +: ACCW]);
      end
    end
  end

  // Accept needs !done and drain needs done, so the two never touch the same row.
  // clr flushes bookkeeping only; buffered data is left in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < ARRWIDTH; l++) begin
          row_buf[r][l] <= '0;
        end
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      done   <= '0;
    end else begin
      if (accept) begin
        for (int l = 0; l < ARRWIDTH; l++) begin
          row_buf[wr_ptr][l] <= new_row[l];
        end
        if (ps_last) begin
          done[wr_ptr] <= 1'b1;
        end
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (drain) begin
        done[rd_ptr] <= 1'b0;
        rd_ptr       <= next_ptr(rd_ptr);
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (ARRWIDTH=2, WORDWIDTH=8, DEPTH=4); inputs driven and
// outputs sampled on the falling edge. Honours PSUM_ACC_SAT_EN for overflow expectations.
module tb_psum_accumulator;
  localparam int ARRWIDTH  = 2;
  localparam int WORDWIDTH = 8;
  localparam int DEPTH     = 4;
  localparam int ACCW      = 32;
  localparam int ADDRW     = 2;
  localparam int VW        = ACCW * ARRWIDTH;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clr;
  logic             ps_valid;
  logic             ps_ready;
  logic             ps_first;
  logic             ps_last;
  logic [VW-1:0]    ps_in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_vec;
  logic [ADDRW-1:0] out_row;

  int n_vec = 0;
  int n_err = 0;
  logic [VW+ADDRW-1:0] exp_q[$];

  psum_accumulator #(.ARRWIDTH(ARRWIDTH), .WORDWIDTH(WORDWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_first(ps_first), .ps_last(ps_last),
    .ps_in_vec(ps_in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_row(out_row)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic first, input logic last,
                            input logic [31:0] l0, input logic [31:0] l1);
    ps_valid  = 1'b1;
    ps_first  = first;
    ps_last   = last;
    ps_in_vec = {l1, l0};
  endtask

  task automatic drive_idle();
    ps_valid  = 1'b0;
    ps_first  = 1'b0;
    ps_last   = 1'b0;
    ps_in_vec = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL reset_ps_ready: got %b expected 1", ps_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_vec !== '0) begin n_err++; $display("FAIL reset_out_vec: got %h expected 0", out_vec); end
    n_vec++; if (out_row !== '0) begin n_err++; $display("FAIL reset_out_row: got %0d expected 0", out_row); end
  endtask

  task automatic test_single_pass();
    logic [31:0] l0s[4] = '{32'd5, 32'd1, 32'd0, 32'd7};
    logic [31:0] l1s[4] = '{32'hFFFF_FFFD, 32'd2, 32'd0, 32'd7};
    logic [VW+ADDRW-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, 1'b1, l0s[i], l1s[i]);
      exp_q.push_back({2'(i), l1s[i], l0s[i]});
      if (i == 0) begin
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got out_valid %b expected 0", out_valid); end
      end
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || {out_row, out_vec} !== exp) begin
        n_err++; $display("FAIL single_row%0d: got v=%b row=%0d vec=%h expected row=%0d vec=%h",
                          i, out_valid, out_row, out_vec, exp[VW+:ADDRW], exp[VW-1:0]);
      end
    end
    drive_idle();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_empty: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_multi_pass();
    logic [VW-1:0] exp;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 4; r++) begin
        drive_beat(p == 0, p == 2, 32'((p + 1) * 10 + r), 32'(r));
        tick();
        if (p < 2) begin
          n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL multi_early_p%0d_r%0d: got out_valid %b expected 0", p, r, out_valid); end
        end else begin
          exp = {32'(3 * r), 32'(60 + 3 * r)};
          n_vec++;
          if (out_valid !== 1'b1 || out_row !== 2'(r) || out_vec !== exp) begin
            n_err++; $display("FAIL multi_row%0d: got v=%b row=%0d vec=%h expected row=%0d vec=%h",
                              r, out_valid, out_row, out_vec, r, exp);
          end
        end
      end
    end
    drive_idle();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL multi_empty: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      drive_beat(1'b1, 1'b1, 32'(r + 1), 32'(100 + r));
      tick();
    end
    drive_beat(1'b1, 1'b1, 32'd500, 32'd600);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (ps_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'd100, 32'd1}) begin
        n_err++; $display("FAIL bp_full_hold%0d: got rdy=%b v=%b row=%0d vec=%h expected rdy=0 v=1 row=0 vec=%h",
                          k, ps_ready, out_valid, out_row, out_vec, {32'd100, 32'd1});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (ps_ready !== 1'b1 || out_row !== 2'd1 || out_vec !== {32'd101, 32'd2}) begin
      n_err++; $display("FAIL bp_after_drain0: got rdy=%b row=%0d vec=%h expected rdy=1 row=1 vec=%h",
                        ps_ready, out_row, out_vec, {32'd101, 32'd2});
    end
    tick();
    drive_idle();
    n_vec++; if (out_row !== 2'd2 || out_vec !== {32'd102, 32'd3}) begin n_err++; $display("FAIL bp_row2: got row=%0d vec=%h expected row=2 vec=%h", out_row, out_vec, {32'd102, 32'd3}); end
    tick();
    n_vec++; if (out_row !== 2'd3 || out_vec !== {32'd103, 32'd4}) begin n_err++; $display("FAIL bp_row3: got row=%0d vec=%h expected row=3 vec=%h", out_row, out_vec, {32'd103, 32'd4}); end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'd600, 32'd500}) begin
      n_err++; $display("FAIL bp_fifth_beat: got v=%b row=%0d vec=%h expected v=1 row=0 vec=%h",
                        out_valid, out_row, out_vec, {32'd600, 32'd500});
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [VW+ADDRW-1:0] exp;
    do_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_beat(1'b1, 1'b1, 32'(10 + i), 32'(20 + i));
      exp_q.push_back({2'(i % 4), 32'(20 + i), 32'(10 + i)});
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if (out_valid !== 1'b1 || {out_row, out_vec} !== exp) begin
        n_err++; $display("FAIL wrap_beat%0d: got v=%b row=%0d vec=%h expected row=%0d vec=%h",
                          i, out_valid, out_row, out_vec, exp[VW+:ADDRW], exp[VW-1:0]);
      end
    end
    drive_idle();
    tick();
    n_vec++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL wrap_no_dup: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pos;
    logic [31:0] exp_neg;
`ifdef PSUM_ACC_SAT_EN
    exp_pos = 32'h7FFF_FFFF;
    exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'h8000_0000;
    exp_neg = 32'h7FFF_FFFF;
`endif
    out_ready = 1'b1;
    do_clr();
    drive_beat(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd3);
    tick();
    for (int r = 1; r < 4; r++) begin drive_beat(1'b1, 1'b0, 32'd0, 32'd0); tick(); end
    drive_beat(1'b0, 1'b1, 32'd1, 32'd4);
    tick();
    drive_idle();
    n_vec++;
    if (out_valid !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'd7, exp_pos}) begin
      n_err++; $display("FAIL ovf_positive: got v=%b row=%0d vec=%h expected v=1 row=0 vec=%h",
                        out_valid, out_row, out_vec, {32'd7, exp_pos});
    end
    tick();
    do_clr();
    drive_beat(1'b1, 1'b0, 32'h8000_0000, 32'd5);
    tick();
    for (int r = 1; r < 4; r++) begin drive_beat(1'b1, 1'b0, 32'd0, 32'd0); tick(); end
    drive_beat(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    drive_idle();
    n_vec++;
    if (out_valid !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'hFFFF_FFFF, exp_neg}) begin
      n_err++; $display("FAIL ovf_negative: got v=%b row=%0d vec=%h expected v=1 row=0 vec=%h",
                        out_valid, out_row, out_vec, {32'hFFFF_FFFF, exp_neg});
    end
    tick();
    do_clr();
  endtask

  task automatic test_abort();
    out_ready = 1'b0;
    drive_beat(1'b1, 1'b1, 32'd9, 32'd9); tick();
    drive_beat(1'b1, 1'b0, 32'd8, 32'd8); tick();
    drive_beat(1'b1, 1'b0, 32'd7, 32'd7); tick();
    drive_idle();
    n_vec++; if (out_valid !== 1'b1 || out_vec !== {32'd9, 32'd9}) begin n_err++; $display("FAIL abort_pre: got v=%b vec=%h expected v=1 vec=%h", out_valid, out_vec, {32'd9, 32'd9}); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (ps_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== '0 || out_row !== '0) begin
      n_err++; $display("FAIL abort_async: got rdy=%b v=%b row=%0d vec=%h expected rdy=1 v=0 row=0 vec=0",
                        ps_ready, out_valid, out_row, out_vec);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive_beat(1'b1, 1'b1, 32'd21, 32'd22); tick();
    drive_beat(1'b1, 1'b0, 32'd3, 32'd3); tick();
    n_vec++; if (out_valid !== 1'b1 || out_row !== 2'd0) begin n_err++; $display("FAIL clr_pre: got v=%b row=%0d expected v=1 row=0", out_valid, out_row); end
    drive_beat(1'b1, 1'b1, 32'd55, 32'd55);
    do_clr();
    drive_idle();
    n_vec++;
    if (out_valid !== 1'b0 || ps_ready !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'd22, 32'd21}) begin
      n_err++; $display("FAIL clr_flush: got v=%b rdy=%b row=%0d vec=%h expected v=0 rdy=1 row=0 vec=%h",
                        out_valid, ps_ready, out_row, out_vec, {32'd22, 32'd21});
    end
    out_ready = 1'b1;
    drive_beat(1'b1, 1'b1, 32'd11, 32'd12);
    tick();
    drive_idle();
    n_vec++;
    if (out_valid !== 1'b1 || out_row !== 2'd0 || out_vec !== {32'd12, 32'd11}) begin
      n_err++; $display("FAIL clr_row0: got v=%b row=%0d vec=%h expected v=1 row=0 vec=%h",
                        out_valid, out_row, out_vec, {32'd12, 32'd11});
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_empty: got out_valid %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
